// File: rtl/seg7_scan_2digit.sv
// seg7_scan_2digit: holds two BCD digits and scans them onto a multiplexed 7-segment display
module seg7_scan_2digit #(
  parameter int REFRESH_CNT = 50000,
  parameter int CNT_W = 16,
  parameter int GUARD = 4,
  parameter bit ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] d_units,
  input  logic [3:0] d_tens,
  input  logic       blank_lz,
  output logic [7:0] seg,
  output logic [1:0] an,
  output logic       frame_done
);
  localparam logic [6:0] DEC [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  localparam logic [7:0] SEG_OFF = ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [1:0] AN_OFF = ACTIVE_LOW ? 2'b11 : 2'b00;
  logic [CNT_W-1:0] cnt;
  logic sel, wrap, off;
  logic [3:0] hold_u, hold_t;
  logic [6:0] pat;
  logic [1:0] an_on;
  always_comb begin
    wrap = cnt == CNT_W'(REFRESH_CNT - 1);
    off = (cnt < CNT_W'(GUARD)) || (sel && blank_lz && hold_t == 4'd0);
    pat = off ? 7'h00 : DEC[sel ? hold_t : hold_u];
    an_on = off ? 2'b00 : (sel ? 2'b10 : 2'b01);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      sel <= 1'b0;
      hold_u <= 4'd0;
      hold_t <= 4'd0;
      frame_done <= 1'b0;
      seg <= SEG_OFF;
      an <= AN_OFF;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      sel <= sel ^ wrap;
      frame_done <= wrap && sel;
      hold_u <= load ? d_units : hold_u;
      hold_t <= load ? d_tens : hold_t;
      seg <= ACTIVE_LOW ? {1'b1, ~pat} : {1'b0, pat};
      an <= ACTIVE_LOW ? ~an_on : an_on;
    end
  end
endmodule

// File: tb/tb_seg7_scan_2digit.sv
// tb_seg7_scan_2digit: scoreboard bench for the two-digit display scanner
module tb_seg7_scan_2digit;
  localparam int RC = 8;
  localparam int G = 2;
  localparam logic [7:0] SEGL [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                       8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};
  logic clk = 1'b0, rst = 1'b1, load = 1'b0, blank_lz = 1'b0;
  logic [3:0] d_units = 4'd0, d_tens = 4'd0;
  logic [7:0] seg;
  logic [1:0] an;
  logic frame_done;
  int checks = 0, failures = 0;
  logic [10:0] q [$];
  int m_cnt = 0;
  bit m_sel = 1'b0;
  logic [3:0] m_u = 4'd0, m_t = 4'd0;

  seg7_scan_2digit #(.REFRESH_CNT(RC), .CNT_W(4), .GUARD(G), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .load(load), .d_units(d_units), .d_tens(d_tens),
    .blank_lz(blank_lz), .seg(seg), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic ld, input logic [3:0] du, input logic [3:0] dt, input logic blz);
    logic off;
    rst = r; load = ld; d_units = du; d_tens = dt; blank_lz = blz;
    off = m_cnt < G || (m_sel && blz && m_t == 4'd0);
    q.push_back(r ? {1'b0, 2'b11, 8'hFF} :
                {m_cnt == RC - 1 && m_sel, off ? 2'b11 : (m_sel ? 2'b01 : 2'b10),
                 off ? 8'hFF : SEGL[m_sel ? m_t : m_u]});
    @(posedge clk);
    #1;
    chk("scan", {frame_done, an, seg}, q.pop_front());
    if (r) begin
      m_cnt = 0; m_sel = 1'b0; m_u = 4'd0; m_t = 4'd0;
    end else begin
      if (ld) begin m_u = du; m_t = dt; end
      if (m_cnt == RC - 1) begin m_cnt = 0; m_sel = !m_sel; end else m_cnt++;
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, d_units, d_tens, blank_lz);
  endtask

  initial begin
    bit s1, s2, s3;
    int last, n;
    repeat (3) step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    chk("rst_an", 11'(an), 11'(2'b11));
    chk("rst_seg", 11'(seg), 11'(8'hFF));
    step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    chk("rel1_an", 11'(an), 11'(2'b11));
    idle();
    chk("rel2_an", 11'(an), 11'(2'b11));
    idle();
    chk("rel3_an", 11'(an), 11'(2'b10));
    step(1'b0, 1'b1, 4'd9, 4'd4, 1'b0);
    s1 = 0; s2 = 0; s3 = 0;
    repeat (16) begin
      idle();
      s1 |= an == 2'b10 && seg == 8'h90;
      s2 |= an == 2'b01 && seg == 8'h99;
      s3 |= an == 2'b11 && seg == 8'hFF;
    end
    chk("units49", 11'(s1), 11'd1);
    chk("tens49", 11'(s2), 11'd1);
    chk("guard", 11'(s3), 11'd1);
    step(1'b0, 1'b1, 4'd7, 4'd0, 1'b1);
    s1 = 0; s2 = 0;
    repeat (16) begin
      idle();
      s1 |= an == 2'b10 && seg == 8'hF8;
      s2 |= an == 2'b01;
    end
    chk("units7", 11'(s1), 11'd1);
    chk("lz_blank", 11'(s2), 11'd0);
    s1 = 0;
    repeat (16) begin
      step(1'b0, 1'b0, d_units, d_tens, 1'b0);
      s1 |= an == 2'b01 && seg == 8'hC0;
    end
    chk("lz_show", 11'(s1), 11'd1);
    step(1'b0, 1'b1, 4'd7, 4'd12, 1'b0);
    s1 = 0;
    repeat (16) begin
      idle();
      s1 |= an == 2'b01 && seg == 8'hBF;
    end
    chk("dash_tens", 11'(s1), 11'd1);
    step(1'b0, 1'b1, 4'd15, 4'd12, 1'b0);
    s1 = 0;
    repeat (16) begin
      idle();
      s1 |= an == 2'b10 && seg == 8'hBF;
    end
    chk("dash_units", 11'(s1), 11'd1);
    s1 = 0;
    for (int i = 0; i < 40 && !s1; i++) begin
      if (m_sel && m_cnt == 5) s1 = 1; else idle();
    end
    chk("seek_t5", 11'(s1), 11'd1);
    step(1'b1, 1'b0, d_units, d_tens, 1'b0);
    chk("mid_rst_an", 11'(an), 11'(2'b11));
    chk("mid_rst_seg", 11'(seg), 11'(8'hFF));
    repeat (3) idle();
    chk("restart_an", 11'(an), 11'(2'b10));
    chk("restart_seg", 11'(seg), 11'(8'hC0));
    last = -1; n = 0;
    for (int i = 0; i < 64; i++) begin
      idle();
      if (frame_done) begin
        if (last >= 0) chk("fd_period", 11'(i - last), 11'd16);
        last = i;
        n++;
      end
    end
    chk("fd_count", 11'(n), 11'd4);
    s1 = 0;
    for (int i = 0; i < 40 && !s1; i++) begin
      if (m_sel && m_cnt == RC - 1) s1 = 1; else idle();
    end
    chk("seek_wrap", 11'(s1), 11'd1);
    step(1'b0, 1'b1, 4'd3, 4'd5, 1'b0);
    chk("wrap_fd", 11'(frame_done), 11'd1);
    idle();
    idle();
    chk("wrap_guard", 11'(an), 11'(2'b11));
    idle();
    chk("wrap_new_an", 11'(an), 11'(2'b10));
    chk("wrap_new_seg", 11'(seg), 11'(8'hB0));
    repeat (10) idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
